// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] F3_DIV  = 3'd4;
    localparam logic [2:0] F3_DIVU = 3'd5;
    localparam logic [2:0] F3_REM  = 3'd6;
    localparam logic [2:0] F3_REMU = 3'd7;

    // Divide-by-zero quotient and the signed-overflow operand pair.
    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    // DIV and REM are the signed flavours (even func3).
    function automatic logic is_signed_op(input logic [2:0] f3);
        return ~f3[0];
    endfunction

    // REM and REMU return the remainder.
    function automatic logic is_rem_op(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry cache of the last completed divider run: operands, signedness, q and r.
module div_result_cache
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        lookup_signed,
    input  logic [31:0] lookup_a,
    input  logic [31:0] lookup_b,
    output logic        hit,
    output logic [31:0] hit_q,
    output logic [31:0] hit_r,
    input  logic        wr_en,
    input  logic        wr_signed,
    input  logic [31:0] wr_a,
    input  logic [31:0] wr_b,
    input  logic [31:0] wr_q,
    input  logic [31:0] wr_r
);

    logic        valid_reg;
    logic        signed_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] q_reg;
    logic [31:0] r_reg;

    // Capture a finished divider result; reset only invalidates the entry.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            valid_reg  <= 1'b0;
            signed_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
        end else if (wr_en) begin
            valid_reg  <= 1'b1;
            signed_reg <= wr_signed;
            a_reg      <= wr_a;
            b_reg      <= wr_b;
            q_reg      <= wr_q;
            r_reg      <= wr_r;
        end
    end

    assign hit   = valid_reg && (signed_reg == lookup_signed)
                && (a_reg == lookup_a) && (b_reg == lookup_b);
    assign hit_q = q_reg;
    assign hit_r = r_reg;

endmodule

// File: rtl/div_sequencer.sv
// Sequences RV32M div/rem: special-case and cache shortcuts, divider handshake, flush drain.
module div_sequencer
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic [2:0]  func3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        start_sdivide,
    output logic        start_udivide,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  result_rd
);

    state_t      state_reg, state_next;
    logic        start_s_reg, start_s_next;
    logic        start_u_reg, start_u_next;
    logic [31:0] result_reg, result_next;
    logic        ready_seen_reg, ready_seen_next;
    logic [31:0] div_a_reg, div_b_reg;
    logic [4:0]  rd_reg;
    logic        signed_reg;
    logic        rem_reg;

    logic        op_valid, op_signed, op_rem;
    logic        accept, div_zero, overflow;
    logic        operands_load, cache_wr;
    logic        cache_hit;
    logic [31:0] cache_q, cache_r;

    assign op_valid  = is_div_op(func3);
    assign op_signed = is_signed_op(func3);
    assign op_rem    = is_rem_op(func3);
    assign accept    = (state_reg == IDLE) && req && op_valid && !flush;

    // Results that the divider must never be asked for.
    assign div_zero  = (rs2 == 32'd0);
    assign overflow  = op_signed && (rs1 == INT_MIN) && (rs2 == NEG_ONE);

    div_result_cache u_cache (
        .clk           (clk),
        .clrn          (clrn),
        .lookup_signed (op_signed),
        .lookup_a      (rs1),
        .lookup_b      (rs2),
        .hit           (cache_hit),
        .hit_q         (cache_q),
        .hit_r         (cache_r),
        .wr_en         (cache_wr),
        .wr_signed     (signed_reg),
        .wr_a          (div_a_reg),
        .wr_b          (div_b_reg),
        .wr_q          (div_q),
        .wr_r          (div_r)
    );

    // Next state, start pulses, result selection and cache write enable.
    always_comb begin
        state_next      = state_reg;
        start_s_next    = 1'b0;
        start_u_next    = 1'b0;
        result_next     = result_reg;
        ready_seen_next = ready_seen_reg;
        operands_load   = 1'b0;
        cache_wr        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (div_zero) begin
                        state_next  = DONE;
                        result_next = op_rem ? rs1 : DIV0_Q;
                    end else if (overflow) begin
                        state_next  = DONE;
                        result_next = op_rem ? 32'd0 : INT_MIN;
                    end else if (cache_hit) begin
                        state_next  = DONE;
                        result_next = op_rem ? cache_r : cache_q;
                    end else begin
                        state_next    = BUSY;
                        start_s_next  = op_signed;
                        start_u_next  = !op_signed;
                        operands_load = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    // A ready in the flush cycle is remembered so DRAIN can leave at once.
                    state_next      = DRAIN;
                    ready_seen_next = div_ready;
                end else if (div_ready) begin
                    state_next  = DONE;
                    result_next = rem_reg ? div_r : div_q;
                    cache_wr    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            DRAIN: begin
                if (div_ready || ready_seen_reg) begin
                    state_next      = IDLE;
                    ready_seen_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state register: FSM state, registered start pulses, drain bookkeeping.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg      <= IDLE;
            start_s_reg    <= 1'b0;
            start_u_reg    <= 1'b0;
            ready_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_s_reg    <= start_s_next;
            start_u_reg    <= start_u_next;
            ready_seen_reg <= ready_seen_next;
        end
    end

    // Datapath registers: captured op, divider operands and the writeback value.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            result_reg <= '0;
            rd_reg     <= '0;
            rem_reg    <= 1'b0;
            div_a_reg  <= '0;
            div_b_reg  <= '0;
            signed_reg <= 1'b0;
        end else begin
            result_reg <= result_next;
            if (accept) begin
                rd_reg  <= rd;
                rem_reg <= op_rem;
            end
            if (operands_load) begin
                div_a_reg  <= rs1;
                div_b_reg  <= rs2;
                signed_reg <= op_signed;
            end
        end
    end

    assign start_sdivide = start_s_reg;
    assign start_udivide = start_u_reg;
    assign div_a         = div_a_reg;
    assign div_b         = div_b_reg;
    assign result        = result_reg;
    assign result_rd     = rd_reg;
    assign result_valid  = (state_reg == DONE) && !flush;
    assign stall         = req && op_valid && !result_valid && !flush;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clrn, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port req, input, 1 bit: an RV32M div/rem sits in EX; the pipeline holds req, func3, rs1, rs2 and rd stable while stall=1.
REQ-004 The block SHALL have the port func3, input, 3 bits: 4=DIV, 5=DIVU, 6=REM, 7=REMU; other codes are ignored.
REQ-005 The block SHALL have the ports rs1 and rs2, input, 32 bits each: dividend and divisor.
REQ-006 The block SHALL have the port rd, input, 5 bits: destination register.
REQ-007 The block SHALL have the port flush, input, 1 bit: kill the in-flight op (branch or interrupt).
REQ-008 The block SHALL have the port start_sdivide, output, 1 bit: one-cycle pulse that starts the signed divider.
REQ-009 The block SHALL have the port start_udivide, output, 1 bit: one-cycle pulse that starts the unsigned divider.
REQ-010 The block SHALL have the ports div_a and div_b, output, 32 bits each: registered operands to the divider.
REQ-011 The block SHALL have the port div_ready, input, 1 bit: one-cycle pulse from the divider when q and r are valid.
REQ-012 The block SHALL have the ports div_q and div_r, input, 32 bits each: divider quotient and remainder.
REQ-013 The block SHALL have the port stall, output, 1 bit: freeze the pipeline front-end.
REQ-014 The block SHALL have the port result_valid, output, 1 bit: result and result_rd are valid this cycle.
REQ-015 The block SHALL have the port result, output, 32 bits: the value to write back.
REQ-016 The block SHALL have the port result_rd, output, 5 bits: the writeback destination.

Function
REQ-017 The block SHALL implement exactly four states, IDLE, BUSY, DONE and DRAIN, with IDLE as the reset state.
REQ-018 In IDLE, with req=1, a valid func3 and flush=0 at an edge, the block SHALL capture op, operands and rd.
REQ-019 On that capture, the block SHALL take the special or cache path if it applies, otherwise go to BUSY with the start pulse asserted in the next cycle (cycle 1).
REQ-020 Special divide-by-zero case (rs2=0): the block SHALL not start the divider and SHALL go to DONE with quotient=32'hFFFFFFFF and remainder=rs1.
REQ-021 Special signed-overflow case (DIV/REM with rs1=32'h80000000 and rs2=32'hFFFFFFFF): the block SHALL not start the divider and SHALL go to DONE with quotient=32'h80000000 and remainder=0.
REQ-022 Fuse-cache case: the block SHALL keep the last divider operands, signedness, q and r, with a valid bit.
REQ-023 On a cache hit (valid, same signedness, equal rs1 and rs2), the block SHALL not start the divider and SHALL go to DONE with the cached values.
REQ-024 In BUSY, start_sdivide (DIV/REM) or start_udivide (DIVU/REMU) SHALL be 1 in the first BUSY cycle only.
REQ-025 In BUSY, on div_ready the block SHALL latch q and r into the result register and the cache, set the cache valid bit, and go to DONE.
REQ-026 In DONE, result_valid SHALL be 1 for exactly one cycle, with result = quotient for DIV/DIVU and remainder for REM/REMU.
REQ-027 The block SHALL go from DONE to IDLE unconditionally, and req SHALL not be sampled in DONE.
REQ-028 stall SHALL equal req & valid func3 & ~result_valid (combinational), and SHALL be 0 when flush=1.
REQ-029 Latency SHALL be 1 cycle for the special and cache paths, and divider latency+1 otherwise.
REQ-030 On flush in BUSY before div_ready, the block SHALL go to DRAIN; div_ready in that same cycle SHALL also go to DRAIN.
REQ-031 DRAIN SHALL wait for div_ready, discard the result, leave the cache unchanged, and return to IDLE.
REQ-032 On flush in DONE, result_valid SHALL be forced to 0 and the state SHALL go to IDLE.
REQ-033 A req arriving while in DRAIN SHALL see stall=1 and SHALL be accepted only after the return to IDLE.
REQ-034 The two start outputs SHALL never be 1 in the same cycle.
REQ-035 The operand comparison SHALL be full 32-bit equality, and signedness SHALL be func3[0]=0.

Reset
REQ-036 While clrn=0 at an edge, the state SHALL be IDLE.
REQ-037 While clrn=0 at an edge, start_sdivide, start_udivide, result_valid and stall-relevant state SHALL be 0.
REQ-038 While clrn=0 at an edge, result, result_rd, div_a and div_b SHALL be 0, and the cache valid bit SHALL be 0.
REQ-039 A reset applied mid-BUSY SHALL abandon the op with no DRAIN; the divider is reset by the same clrn.

Structure
REQ-040 A shared package div_pkg SHALL hold the state enum and the func3 constants DIV/DIVU/REM/REMU.
REQ-041 div_pkg SHALL also hold DIV0_Q = 32'hFFFFFFFF and the overflow constants INT_MIN and NEG_ONE.
REQ-042 One sub-module, div_result_cache, SHALL hold the operand/q/r cache with the hit compare and the valid bit.
REQ-043 The special-case detect SHALL remain inline in div_sequencer.

Verification
REQ-044 The bench SHALL run DIVU 100/7 with a divider of latency 33 and check: one start_udivide pulse in cycle 1, result_valid in cycle 35 with result=14 and rd echoed, stall high in cycles 0..34.
REQ-045 The bench SHALL run DIV 7/0 and REMU 7/0 and check: no start pulse, result_valid in cycle 1 with results FFFFFFFF and 7 respectively.
REQ-046 The bench SHALL run DIV 80000000/FFFFFFFF then REM on the same operands and check results 80000000 then 0, with no start pulse either time.
REQ-047 The bench SHALL run DIV -20/3 (divider run, result FFFFFFFA) followed by REM -20/3 and check: cache hit, no start, result FFFFFFFE after 1 cycle.
REQ-048 The bench SHALL assert flush 5 cycles into BUSY and check: DRAIN until div_ready, no result_valid, cache unchanged, next DIVU accepted only after the return to IDLE.
REQ-049 The bench SHALL pull clrn low mid-BUSY and check: all outputs 0 and state IDLE next cycle; a subsequent identical op misses the cache and restarts the divider.
